dcache_wb: RTL and testbench
============================

Name: dcache_wb

Overview:
- Parametrised, direct-mapped, write-back, write-allocate data cache. Sits between the CPU memory stage and the line-wide data memory.
- Replaces the fixed 4-set, 256-bit-line cache.
- New capabilities:
  - explicit request/done handshake toward the CPU;
  - req/ack handshake toward memory, so memory latency is arbitrary;
  - per-byte write enables;
  - whole-cache flush.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, CPU word width; multiple of 8.
- LINE_WORDS, 8, words per line; power of two.
- SETS, 4, number of lines; power of two.
- Derived:
  - OFF_W = log2(LINE_WORDS*DATA_W/8)
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_W - IDX_W - OFF_W
  - LINE_W = LINE_WORDS*DATA_W

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_rd  in  1  read request; sampled in IDLE only.
- cpu_wr  in  1  write request; sampled in IDLE only; cpu_wr has priority if both rd and wr are high.
- cpu_addr  in  ADDR_W  byte address; word-aligned (low log2(DATA_W/8) bits ignored).
- cpu_wdata  in  DATA_W  write data.
- cpu_be  in  DATA_W/8  byte enables; bit i selects byte i (bits 8i+7:8i).
- cpu_flush  in  1  write back all dirty lines and invalidate the whole cache.
- cpu_rdata  out  DATA_W  read data; valid while cpu_done=1.
- cpu_done  out  1  one-cycle pulse marking completion of rd, wr or flush.
- cpu_busy  out  1  high in every state except IDLE.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  1 = line write-back, 0 = line fill.
- mem_addr  out  ADDR_W  line-aligned address (low OFF_W bits zero).
- mem_wdata  out  LINE_W  victim line.
- mem_rdata  in  LINE_W  fill data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse from memory.

Behaviour:
- Address split:
  - offset = addr[OFF_W-1:0]; word select = offset >> log2(DATA_W/8);
  - index = addr[OFF_W+IDX_W-1:OFF_W];
  - tag = remaining upper bits.
- Word w of a line occupies bits [w*DATA_W +: DATA_W] (little-endian, word 0 at the LSBs). Line data is identical in cache and memory.
- Storage per set: tag, valid, dirty, line.
- Reset:
  - all valid and dirty bits cleared;
  - FSM returns to IDLE from any state, abandoning any outstanding memory transaction;
  - cpu_done=0, cpu_busy=0, mem_req=0, mem_we=0, cpu_rdata=0.
  - Memory tolerates a dropped request.
- FSM states: IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB.
- IDLE:
  - on rd/wr, register address, data and be, then evaluate hit = valid & tag match.
  - Hit: complete in the same cycle. cpu_done pulses on the next edge, so latency is 1 cycle.
    - Read: cpu_rdata = selected word.
    - Write: merge enabled bytes and set dirty.
  - Miss with a dirty victim: go to WB with mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line.
  - Miss otherwise: go to FILL.
- WB: hold outputs stable until mem_ack, then clear dirty and go to FILL.
- FILL:
  - mem_we=0, mem_addr={req tag, index, 0}.
  - On mem_ack: line <= mem_rdata, write tag, set valid.
  - The pending write merge is applied in the same edge and sets dirty; a read latches cpu_rdata from mem_rdata.
  - Pulse cpu_done next cycle and return to IDLE.
- Miss latency = 1 + WB cycles + FILL cycles.
- Flush:
  - cpu_flush in IDLE (priority over rd/wr) enters FLUSH_SCAN with counter = 0.
  - Each FLUSH_SCAN cycle examines set[counter]:
    - if dirty, go to FLUSH_WB, then return on mem_ack with dirty cleared;
    - otherwise clear valid and increment.
  - After set SETS-1, all valid bits are 0. cpu_done pulses and the FSM returns to IDLE.
- Requests arriving while busy are ignored; the CPU must hold them until done.
- cpu_be=0 on a write still allocates the line but leaves data and dirty unchanged. A hit leaves dirty unchanged; a miss leaves dirty clear.
- mem_ack outside WB, FILL or FLUSH_WB is ignored.
- cpu_rdata holds its last value outside done cycles.

Decomposition:
- Shared package dcache_pkg holds:
  - the FSM state enum;
  - the OFF_W/IDX_W/TAG_W derivation helpers (clog2-based);
  - the address field-extraction functions.
- One natural sub-module, dcache_line_merge: combinational; inputs line, word index, wdata and be; output is the merged line. It is reused by the hit path and the fill path.

Test Plan (defaults; memory model with 3-cycle ack):
- Read miss, clean:
  - stimulus: rst, then rd 0x0000_0020;
  - response: mem_req with we=0, addr 0x20; after ack, cpu_rdata = word 0 of the fill line; cpu_done 5 cycles after the request.
- Read hit:
  - stimulus: rd 0x0000_0024 immediately after the previous test;
  - response: cpu_done on the next cycle, rdata = fill word 1, no mem_req.
- Byte-enable write hit then read:
  - stimulus: wr 0x24 data 0xAABBCCDD be 4'b0101, then rd 0x24;
  - response: rdata = {fill[31:24], 0xBB, fill[15:8], 0xDD}; no memory traffic.
- Dirty eviction:
  - stimulus: rd 0x0000_00A0 (same index 1, new tag) after the previous test;
  - response: WB with addr 0x20 carrying the merged line, then FILL at addr 0xA0.
- Flush:
  - stimulus: make sets 0 and 2 dirty, then pulse cpu_flush;
  - response: exactly two write-backs in index order 0 then 2, a single cpu_done, and every following access misses.
- Reset mid-FILL:
  - stimulus: assert rst while mem_req=1;
  - response: next cycle mem_req=0, busy=0; a subsequent rd of the same address misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared definitions for the dcache_wb data cache: FSM state
//            encoding, address-geometry derivation helpers and address
//            field-extraction functions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WB         = 3'd1,
        ST_FILL       = 3'd2,
        ST_FLUSH_SCAN = 3'd3,
        ST_FLUSH_WB   = 3'd4
    } state_t;

    // Byte-offset width inside one line.
    function automatic int calc_off_w(input int line_words, input int data_w);
        return $clog2(line_words * (data_w / 8));
    endfunction

    // Set-index width.
    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag width: whatever the offset and index leave of the address.
    function automatic int calc_tag_w(input int addr_w, input int off_w, input int idx_w);
        return addr_w - off_w - idx_w;
    endfunction

    // Width of the word-select field inside a line.
    function automatic int calc_wsel_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Generic field extraction on a zero-extended address.
    function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                               input int          lsb,
                                               input int          width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (addr >> lsb) & mask;
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                               input int          off_w,
                                               input int          idx_w);
        return addr_field(addr, off_w, idx_w);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                             input int          off_w,
                                             input int          idx_w,
                                             input int          tag_w);
        return addr_field(addr, off_w + idx_w, tag_w);
    endfunction

    // Word select skips the byte-in-word bits, which are ignored.
    function automatic logic [63:0] addr_word(input logic [63:0] addr,
                                              input int          data_w,
                                              input int          wsel_w);
        return addr_field(addr, $clog2(data_w / 8), wsel_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_line_merge.sv
// ============================================================================
// Module   : dcache_line_merge
// Purpose  : Combinational byte-enable merge of one CPU word into a cache
//            line. Bytes of the selected word whose enable is set take the
//            write data; every other byte passes through unchanged.
// Ports    : i_line  - line to merge into
//            i_word  - word index within the line
//            i_wdata - write data word
//            i_be    - byte enables, bit i covers bits 8i+7:8i
//            o_line  - merged line
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_line_merge
    import dcache_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic [LINE_WORDS*DATA_W-1:0]          i_line,
    input  logic [calc_wsel_w(LINE_WORDS)-1:0]    i_word,
    input  logic [DATA_W-1:0]                     i_wdata,
    input  logic [DATA_W/8-1:0]                   i_be,
    output logic [LINE_WORDS*DATA_W-1:0]          o_line
);

    localparam int c_WSEL_W = calc_wsel_w(LINE_WORDS);
    localparam int c_BE_W   = DATA_W / 8;

    for (genvar w = 0; w < LINE_WORDS; w++) begin : g_word
        localparam logic [c_WSEL_W-1:0] c_W = c_WSEL_W'(w);
        for (genvar b = 0; b < c_BE_W; b++) begin : g_byte
            assign o_line[w*DATA_W + 8*b +: 8] =
                ((i_word == c_W) && i_be[b]) ? i_wdata[8*b +: 8]
                                             : i_line[w*DATA_W + 8*b +: 8];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dcache_wb.sv
// ============================================================================
// Module   : dcache_wb
// Purpose  : Parametrised direct-mapped, write-back, write-allocate data
//            cache between the CPU memory stage and a line-wide memory.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            cpu_rd / cpu_wr       - read / write request (sampled in IDLE)
//            cpu_addr, cpu_wdata,
//            cpu_be                - address, write data, byte enables
//            cpu_flush             - write back dirty lines, invalidate all
//            cpu_rdata, cpu_done   - read data, one-cycle completion pulse
//            cpu_busy              - high whenever not IDLE
//            mem_req/mem_we/mem_addr/mem_wdata - line request to memory
//            mem_rdata/mem_ack     - fill data and completion pulse
// Notes    : SETS and LINE_WORDS are assumed to be at least 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_wb
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int SETS       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_rd,
    input  logic                          cpu_wr,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_wdata,
    input  logic [DATA_W/8-1:0]           cpu_be,
    input  logic                          cpu_flush,
    output logic [DATA_W-1:0]             cpu_rdata,
    output logic                          cpu_done,
    output logic                          cpu_busy,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [LINE_WORDS*DATA_W-1:0]  mem_wdata,
    input  logic [LINE_WORDS*DATA_W-1:0]  mem_rdata,
    input  logic                          mem_ack
);

    localparam int c_OFF_W  = calc_off_w(LINE_WORDS, DATA_W);
    localparam int c_IDX_W  = calc_idx_w(SETS);
    localparam int c_TAG_W  = calc_tag_w(ADDR_W, c_OFF_W, c_IDX_W);
    localparam int c_WSEL_W = calc_wsel_w(LINE_WORDS);
    localparam int c_LINE_W = LINE_WORDS * DATA_W;
    localparam int c_BE_W   = DATA_W / 8;
    localparam logic [c_IDX_W-1:0] c_LAST_SET = c_IDX_W'(SETS - 1);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [c_LINE_W-1:0] r_line [SETS];
    logic [c_TAG_W-1:0]  r_tag  [SETS];
    logic [SETS-1:0]     r_valid;
    logic [SETS-1:0]     r_dirty;

    // Registered request, held across WB/FILL.
    logic [c_TAG_W-1:0]  r_req_tag;
    logic [c_IDX_W-1:0]  r_req_idx;
    logic [c_WSEL_W-1:0] r_req_word;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_BE_W-1:0]   r_be;
    logic                r_is_wr;

    logic [c_IDX_W-1:0]  r_cnt;
    logic                r_done;
    logic [DATA_W-1:0]   r_rdata;

    state_t              r_state;
    state_t              w_next;

    // ------------------------------------------------------------------
    // Address decode of the incoming request
    // ------------------------------------------------------------------
    logic [63:0]         w_addr64;
    logic [c_IDX_W-1:0]  w_in_idx;
    logic [c_TAG_W-1:0]  w_in_tag;
    logic [c_WSEL_W-1:0] w_in_word;
    logic                w_hit;
    logic                w_victim_dirty;
    logic [c_LINE_W-1:0] w_cur_line;
    logic [DATA_W-1:0]   w_cur_word;
    logic [DATA_W-1:0]   w_fill_word;

    assign w_addr64       = 64'(cpu_addr);
    assign w_in_idx       = c_IDX_W'(addr_index(w_addr64, c_OFF_W, c_IDX_W));
    assign w_in_tag       = c_TAG_W'(addr_tag(w_addr64, c_OFF_W, c_IDX_W, c_TAG_W));
    assign w_in_word      = c_WSEL_W'(addr_word(w_addr64, DATA_W, c_WSEL_W));
    assign w_hit          = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);
    assign w_victim_dirty = r_valid[w_in_idx] && r_dirty[w_in_idx];
    assign w_cur_line     = r_line[w_in_idx];
    assign w_cur_word     = w_cur_line[w_in_word*DATA_W +: DATA_W];
    assign w_fill_word    = mem_rdata[r_req_word*DATA_W +: DATA_W];

    // ------------------------------------------------------------------
    // Shared merge: in IDLE it merges a write hit into the resident line,
    // in FILL it merges the pending write into the incoming fill line.
    // ------------------------------------------------------------------
    logic [c_LINE_W-1:0] w_mg_line;
    logic [c_WSEL_W-1:0] w_mg_word;
    logic [DATA_W-1:0]   w_mg_wdata;
    logic [c_BE_W-1:0]   w_mg_be;
    logic [c_LINE_W-1:0] w_merged;

    always_comb begin
        if (r_state == ST_IDLE) begin
            w_mg_line  = w_cur_line;
            w_mg_word  = w_in_word;
            w_mg_wdata = cpu_wdata;
            w_mg_be    = cpu_be;
        end else begin
            w_mg_line  = mem_rdata;
            w_mg_word  = r_req_word;
            w_mg_wdata = r_wdata;
            w_mg_be    = r_be;
        end
    end

    dcache_line_merge #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_merge (
        .i_line  (w_mg_line),
        .i_word  (w_mg_word),
        .i_wdata (w_mg_wdata),
        .i_be    (w_mg_be),
        .o_line  (w_merged)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cpu_flush) begin
                    w_next = ST_FLUSH_SCAN;
                end else if (cpu_rd || cpu_wr) begin
                    if (w_hit) begin
                        w_next = ST_IDLE;
                    end else if (w_victim_dirty) begin
                        w_next = ST_WB;
                    end else begin
                        w_next = ST_FILL;
                    end
                end
            end
            ST_WB: begin
                if (mem_ack) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    w_next = ST_IDLE;
                end
            end
            ST_FLUSH_SCAN: begin
                if (r_dirty[r_cnt]) begin
                    w_next = ST_FLUSH_WB;
                end else if (r_cnt == c_LAST_SET) begin
                    w_next = ST_IDLE;
                end
            end
            ST_FLUSH_WB: begin
                // Return to the same set; it is now clean and gets invalidated.
                if (mem_ack) begin
                    w_next = ST_FLUSH_SCAN;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs toward memory (stable for the whole request since they
    // depend only on registered state)
    // ------------------------------------------------------------------
    always_comb begin
        cpu_busy  = (r_state != ST_IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag[r_req_idx], r_req_idx, {c_OFF_W{1'b0}}};
                mem_wdata = r_line[r_req_idx];
            end
            ST_FILL: begin
                mem_req   = 1'b1;
                mem_addr  = {r_req_tag, r_req_idx, {c_OFF_W{1'b0}}};
            end
            ST_FLUSH_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag[r_cnt], r_cnt, {c_OFF_W{1'b0}}};
                mem_wdata = r_line[r_cnt];
            end
            default: begin
            end
        endcase
    end

    assign cpu_done  = r_done;
    assign cpu_rdata = r_rdata;

    // ------------------------------------------------------------------
    // Control state: valid/dirty, request capture, read data, flush counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_dirty    <= '0;
            r_done     <= 1'b0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_req_tag  <= '0;
            r_req_idx  <= '0;
            r_req_word <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_is_wr    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cpu_flush) begin
                        r_cnt <= '0;
                    end else if (cpu_rd || cpu_wr) begin
                        r_req_tag  <= w_in_tag;
                        r_req_idx  <= w_in_idx;
                        r_req_word <= w_in_word;
                        r_wdata    <= cpu_wdata;
                        r_be       <= cpu_be;
                        r_is_wr    <= cpu_wr;
                        if (w_hit) begin
                            r_done <= 1'b1;
                            if (cpu_wr) begin
                                // An all-zero byte mask changes nothing, so
                                // the line must not become dirty.
                                if (|cpu_be) begin
                                    r_dirty[w_in_idx] <= 1'b1;
                                end
                            end else begin
                                r_rdata <= w_cur_word;
                            end
                        end
                    end
                end
                ST_WB: begin
                    if (mem_ack) begin
                        r_dirty[r_req_idx] <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        r_valid[r_req_idx] <= 1'b1;
                        r_dirty[r_req_idx] <= r_is_wr && (|r_be);
                        if (!r_is_wr) begin
                            r_rdata <= w_fill_word;
                        end
                        r_done <= 1'b1;
                    end
                end
                ST_FLUSH_SCAN: begin
                    if (!r_dirty[r_cnt]) begin
                        r_valid[r_cnt] <= 1'b0;
                        if (r_cnt == c_LAST_SET) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_IDX_W'(1);
                        end
                    end
                end
                ST_FLUSH_WB: begin
                    if (mem_ack) begin
                        r_dirty[r_cnt] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line and tag arrays (not reset; guarded by the valid bits)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((r_state == ST_IDLE) && !cpu_flush && cpu_wr && w_hit) begin
                r_line[w_in_idx] <= w_merged;
            end
            if ((r_state == ST_FILL) && mem_ack) begin
                r_line[r_req_idx] <= r_is_wr ? w_merged : mem_rdata;
                r_tag[r_req_idx]  <= r_req_tag;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dcache_wb.sv
// ============================================================================
// Module   : tb_dcache_wb
// Purpose  : Self-checking bench for dcache_wb. A memory responder acks each
//            request a fixed number of cycles after it appears; a reference
//            model tracks which line each set holds, its dirty state, and the
//            CPU-visible contents of memory, and predicts read data, memory
//            traffic and completion latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_wb;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 8;
    localparam int SETS       = 4;
    localparam int LAT        = 3;
    localparam int LINE_B     = LINE_WORDS * DATA_W / 8;
    localparam int LINE_W     = LINE_WORDS * DATA_W;

    logic              clk;
    logic              rst;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [3:0]        cpu_be;
    logic              cpu_flush;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;
    logic              cpu_busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ack;

    dcache_wb #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_flush (cpu_flush),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_busy  (cpu_busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [31:0]       addr;
        logic [LINE_W-1:0] data;
    } txn_t;

    txn_t              act_q[$];
    txn_t              exp_q[$];
    logic [LINE_W-1:0] mem_store [logic [31:0]];
    logic [31:0]       gold      [logic [31:0]];
    bit                m_valid [SETS];
    bit                m_dirty [SETS];
    logic [31:0]       m_laddr [SETS];
    int                n_checks;
    int                n_err;

    // Deterministic power-on memory content.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        if (mem_store.exists(la)) return mem_store[la];
        for (int w = 0; w < LINE_WORDS; w++) l[w*32 +: 32] = init_word(la + 32'(4*w));
        return l;
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        if (gold.exists(a)) return gold[a];
        return init_word(a);
    endfunction

    function automatic logic [LINE_W-1:0] gold_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < LINE_WORDS; w++) l[w*32 +: 32] = gold_word(la + 32'(4*w));
        return l;
    endfunction

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: ack in the (LAT+1)-th cycle a request is held.
    initial begin
        int   cnt;
        txn_t t;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst || !mem_req) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == LAT + 1) begin
                    t.we   = mem_we;
                    t.addr = mem_addr;
                    t.data = mem_wdata;
                    act_q.push_back(t);
                    if (mem_we) mem_store[mem_addr] = mem_wdata;
                    else        mem_rdata = mem_line(mem_addr);
                    mem_ack = 1'b1;
                    cnt     = 0;
                end
            end
        end
    end

    task automatic wait_done(output int cyc);
        bit seen;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cpu_done) seen = 1;
            else if (cyc == 1) chk("busy_during_miss", LINE_W'(cpu_busy), LINE_W'(1));
        end
        if (!seen) chk("done_timeout", LINE_W'(cpu_done), LINE_W'(1));
    endtask

    task automatic check_traffic();
        chk("txn_count", LINE_W'(act_q.size()), LINE_W'(exp_q.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            chk("txn_we", LINE_W'(act_q[i].we), LINE_W'(exp_q[i].we));
            chk("txn_addr", LINE_W'(act_q[i].addr), LINE_W'(exp_q[i].addr));
            if (exp_q[i].we) chk("wb_data", act_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic access(input bit is_wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input bit also_rd);
        logic [31:0] wa;
        logic [31:0] la;
        logic [31:0] g;
        int          idx;
        int          cyc;
        int          exp_lat;
        bit          hit;
        txn_t        t;
        wa  = addr & ~32'h3;
        la  = addr & ~32'(LINE_B - 1);
        idx = int'((la / LINE_B) % SETS);
        exp_q.delete();
        hit = m_valid[idx] && (m_laddr[idx] == la);
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                t.we = 1'b1; t.addr = m_laddr[idx]; t.data = gold_line(m_laddr[idx]);
                exp_q.push_back(t);
            end
            t.we = 1'b0; t.addr = la; t.data = '0;
            exp_q.push_back(t);
            m_valid[idx] = 1; m_laddr[idx] = la; m_dirty[idx] = 0;
        end
        if (is_wr && be != 4'd0) begin
            g = gold_word(wa);
            for (int b = 0; b < 4; b++) if (be[b]) g[8*b +: 8] = wdata[8*b +: 8];
            gold[wa]     = g;
            m_dirty[idx] = 1;
        end
        exp_lat = 1 + exp_q.size() * (LAT + 1);

        @(negedge clk);
        act_q.delete();
        cpu_rd    = is_wr ? also_rd : 1'b1;
        cpu_wr    = is_wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
        wait_done(cyc);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        chk("latency", LINE_W'(cyc), LINE_W'(exp_lat));
        if (!is_wr) chk("rdata", LINE_W'(cpu_rdata), LINE_W'(gold_word(wa)));
        check_traffic();
    endtask

    task automatic do_flush();
        int   nd;
        int   cyc;
        int   exp_lat;
        txn_t t;
        exp_q.delete();
        nd = 0;
        for (int s = 0; s < SETS; s++) begin
            if (m_valid[s] && m_dirty[s]) begin
                t.we = 1'b1; t.addr = m_laddr[s]; t.data = gold_line(m_laddr[s]);
                exp_q.push_back(t);
                nd++;
            end
            m_valid[s] = 0;
            m_dirty[s] = 0;
        end
        // One scan cycle per set, plus for each dirty set a scan cycle that
        // launches the write-back and the write-back itself.
        exp_lat = 1 + SETS + nd * (LAT + 2);

        @(negedge clk);
        act_q.delete();
        cpu_flush = 1'b1;
        wait_done(cyc);
        cpu_flush = 1'b0;
        chk("flush_latency", LINE_W'(cyc), LINE_W'(exp_lat));
        check_traffic();
        @(posedge clk);
        #1;
        chk("flush_single_done", LINE_W'(cpu_done), LINE_W'(0));
    endtask

    initial begin
        logic [31:0] f;
        logic [31:0] ra;
        int          cyc;
        n_checks  = 0;
        n_err     = 0;
        rst       = 1'b1;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_be    = '0;
        cpu_flush = 1'b0;
        for (int s = 0; s < SETS; s++) begin
            m_valid[s] = 0; m_dirty[s] = 0; m_laddr[s] = '0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done",  LINE_W'(cpu_done),  LINE_W'(0));
        chk("rst_busy",  LINE_W'(cpu_busy),  LINE_W'(0));
        chk("rst_req",   LINE_W'(mem_req),   LINE_W'(0));
        chk("rst_we",    LINE_W'(mem_we),    LINE_W'(0));
        chk("rst_rdata", LINE_W'(cpu_rdata), LINE_W'(0));
        @(negedge clk);
        rst = 1'b0;

        // Clean read miss, then read hit on the same line.
        access(0, 32'h0000_0020, 32'h0, 4'h0, 0);
        access(0, 32'h0000_0024, 32'h0, 4'h0, 0);

        // Partial byte-enable write hit, then read back.
        access(1, 32'h0000_0024, 32'hAABB_CCDD, 4'b0101, 0);
        access(0, 32'h0000_0024, 32'h0, 4'h0, 0);
        f = init_word(32'h24);
        chk("be_merge", LINE_W'(cpu_rdata), LINE_W'({f[31:24], 8'hBB, f[15:8], 8'hDD}));

        // Dirty eviction of set 1.
        access(0, 32'h0000_00A0, 32'h0, 4'h0, 0);

        // Dirty sets 0 and 2 (write with rd also high), then flush.
        access(1, 32'h0000_0000, 32'h1122_3344, 4'hF, 1);
        access(1, 32'h0000_0044, 32'h5566_7788, 4'hF, 0);
        do_flush();
        access(0, 32'h0000_0000, 32'h0, 4'h0, 0);
        access(0, 32'h0000_00A0, 32'h0, 4'h0, 0);

        // Zero byte-enable write: allocates but stays clean.
        access(1, 32'h0000_0160, 32'hDEAD_BEEF, 4'h0, 0);
        access(0, 32'h0000_0160, 32'h0, 4'h0, 0);

        // Randomised traffic over four tags per set.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush();
            end else begin
                ra = 32'($urandom_range(0, 15) * LINE_B + $urandom_range(0, 7) * 4
                         + $urandom_range(0, 3));
                access(1'($urandom_range(0, 1)), ra, $urandom,
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
        end
        do_flush();

        // Reset in the middle of a fill.
        @(negedge clk);
        cpu_rd   = 1'b1;
        cpu_addr = 32'h0000_0300;
        cyc      = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!mem_req && cyc < 20);
        chk("midfill_req_seen", LINE_W'(mem_req), LINE_W'(1));
        @(negedge clk);
        rst    = 1'b1;
        cpu_rd = 1'b0;
        @(posedge clk);
        #1;
        chk("midfill_rst_req",  LINE_W'(mem_req),  LINE_W'(0));
        chk("midfill_rst_busy", LINE_W'(cpu_busy), LINE_W'(0));
        chk("midfill_rst_done", LINE_W'(cpu_done), LINE_W'(0));
        @(negedge clk);
        rst = 1'b0;
        access(0, 32'h0000_0300, 32'h0, 4'h0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
